// File: rtl/quad_encoder_bank_pkg.sv
// Shared definitions for the quadrature encoder bank: Gray states of the AB pair,
// phase accumulator geometry and the edge classifier used by every channel.
package quad_encoder_bank_pkg;

    localparam logic [1:0] AB_IDLE = 2'b11;
    localparam logic [1:0] AB_01   = 2'b01;
    localparam logic [1:0] AB_00   = 2'b00;
    localparam logic [1:0] AB_10   = 2'b10;

    localparam int PH_W = 3;
    localparam logic [PH_W-1:0] PH_ONE  = 3'b001;
    // +4 and -4 share this encoding in a signed 3-bit accumulator; the final edge direction disambiguates
    localparam logic [PH_W-1:0] PH_FULL = 3'b100;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_CW   = 2'd1,
        STEP_CCW  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            AB_IDLE: nxt = AB_01;
            AB_01:   nxt = AB_00;
            AB_00:   nxt = AB_10;
            AB_10:   nxt = AB_IDLE;
            default: nxt = AB_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic step_e classify(input logic [1:0] old_ab, input logic [1:0] new_ab);
        step_e st;
        if (old_ab == new_ab) begin
            st = STEP_NONE;
        end else if ((old_ab ^ new_ab) == 2'b11) begin
            st = STEP_ERR;
        end else if (new_ab == cw_next(old_ab)) begin
            st = STEP_CW;
        end else begin
            st = STEP_CCW;
        end
        return st;
    endfunction

endpackage

// File: rtl/quad_encoder_chan.sv
// One encoder channel: pin synchroniser, debounce, quadrature decoder with detent
// accumulation, and the saturating/wrapping position counter with load.
module quad_encoder_chan
    import quad_encoder_bank_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_CNT = 255,
    parameter int DEB_LEN = 8,
    parameter int DETENT  = 1,
    parameter int WRAP    = 0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             a,
    input  logic             b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             inc,
    output logic             dec,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_CNT);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [1:0]         sync_a_r, sync_b_r;
    logic [DEB_LEN-2:0] hist_a_r, hist_b_r;
    logic [DEB_LEN-1:0] win_a_s, win_b_s;
    logic [1:0]         deb_r, deb_nxt_s, prev_r;
    logic [PH_W-1:0]    phase_r, ph_step_s, ph_nxt_s;
    logic [WIDTH-1:0]   count_r, cnt_nxt_s;
    logic               inc_r, dec_r, err_r;
    logic               inc_s, dec_s, err_s;
    logic               is_cw_s, is_ccw_s, at_idle_s;
    step_e              step_s;

    // Debounce window: the newest synchronised sample plus DEB_LEN-1 older ones
    always_comb begin
        win_a_s   = {hist_a_r, sync_a_r[1]};
        win_b_s   = {hist_b_r, sync_b_r[1]};
        deb_nxt_s = deb_r;
        if (&win_a_s) begin
            deb_nxt_s[1] = 1'b1;
        end else if (~|win_a_s) begin
            deb_nxt_s[1] = 1'b0;
        end else begin
            deb_nxt_s[1] = deb_r[1];
        end
        if (&win_b_s) begin
            deb_nxt_s[0] = 1'b1;
        end else if (~|win_b_s) begin
            deb_nxt_s[0] = 1'b0;
        end else begin
            deb_nxt_s[0] = deb_r[0];
        end
    end

    // Synchroniser, debounce history and accepted pin state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_a_r <= 2'b11;
            sync_b_r <= 2'b11;
            hist_a_r <= {(DEB_LEN-1){1'b1}};
            hist_b_r <= {(DEB_LEN-1){1'b1}};
            deb_r    <= AB_IDLE;
        end else begin
            sync_a_r <= {sync_a_r[0], a};
            sync_b_r <= {sync_b_r[0], b};
            hist_a_r <= win_a_s[DEB_LEN-2:0];
            hist_b_r <= win_b_s[DEB_LEN-2:0];
            deb_r    <= deb_nxt_s;
        end
    end

    // Edge decode, detent accumulation and next counter value
    always_comb begin
        step_s    = classify(prev_r, deb_r);
        is_cw_s   = (step_s == STEP_CW);
        is_ccw_s  = (step_s == STEP_CCW);
        err_s     = (step_s == STEP_ERR);
        at_idle_s = (deb_r == AB_IDLE);
        case (step_s)
            STEP_CW:  ph_step_s = phase_r + PH_ONE;
            STEP_CCW: ph_step_s = phase_r - PH_ONE;
            STEP_ERR: ph_step_s = {PH_W{1'b0}};
            default:  ph_step_s = phase_r;
        endcase
        ph_nxt_s = (at_idle_s || err_s) ? {PH_W{1'b0}} : ph_step_s;
        if (DETENT != 0) begin
            inc_s = is_cw_s  && at_idle_s && (ph_step_s == PH_FULL);
            dec_s = is_ccw_s && at_idle_s && (ph_step_s == PH_FULL);
        end else begin
            inc_s = is_cw_s;
            dec_s = is_ccw_s;
        end
        // A load takes the slot; a coincident step still pulses but is dropped
        if (load) begin
            cnt_nxt_s = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (inc_s) begin
            if (count_r >= MAX_V) begin
                cnt_nxt_s = (WRAP != 0) ? {WIDTH{1'b0}} : MAX_V;
            end else begin
                cnt_nxt_s = count_r + ONE_V;
            end
        end else if (dec_s) begin
            if (count_r == {WIDTH{1'b0}}) begin
                cnt_nxt_s = (WRAP != 0) ? MAX_V : {WIDTH{1'b0}};
            end else begin
                cnt_nxt_s = count_r - ONE_V;
            end
        end else begin
            cnt_nxt_s = count_r;
        end
    end

    // Decoder state, counter and registered event pulses
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_r  <= AB_IDLE;
            phase_r <= {PH_W{1'b0}};
            count_r <= {WIDTH{1'b0}};
            inc_r   <= 1'b0;
            dec_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            prev_r  <= deb_r;
            phase_r <= ph_nxt_s;
            count_r <= cnt_nxt_s;
            inc_r   <= inc_s;
            dec_r   <= dec_s;
            err_r   <= err_s;
        end
    end

    assign count = count_r;
    assign inc   = inc_r;
    assign dec   = dec_r;
    assign err   = err_r;

endmodule

// File: rtl/quad_encoder_bank.sv
// Bank of independent quadrature encoder channels; packs per-channel counters
// into one bus with channel i at [i*WIDTH +: WIDTH].
module quad_encoder_bank
    import quad_encoder_bank_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int WIDTH   = 8,
    parameter int MAX_CNT = 255,
    parameter int DEB_LEN = 8,
    parameter int DETENT  = 1,
    parameter int WRAP    = 0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [N_CH-1:0]       A,
    input  logic [N_CH-1:0]       B,
    input  logic [N_CH-1:0]       load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [N_CH*WIDTH-1:0] count,
    output logic [N_CH-1:0]       inc,
    output logic [N_CH-1:0]       dec,
    output logic [N_CH-1:0]       err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        quad_encoder_chan #(
            .WIDTH   (WIDTH),
            .MAX_CNT (MAX_CNT),
            .DEB_LEN (DEB_LEN),
            .DETENT  (DETENT),
            .WRAP    (WRAP)
        ) u_chan (
            .CLK      (CLK),
            .RESET_N  (RESET_N),
            .a        (A[i]),
            .b        (B[i]),
            .load     (load[i]),
            .load_val (load_val),
            .count    (count[i*WIDTH +: WIDTH]),
            .inc      (inc[i]),
            .dec      (dec[i]),
            .err      (err[i])
        );
    end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Bench for quad_encoder_bank: three parameterisations share one set of pins and
// are compared each cycle against a displacement-counting reference model.
module tb_quad_encoder_bank;

    localparam int N_CH   = 2;
    localparam int WIDTH  = 8;
    localparam int DEB    = 8;
    localparam int N_INST = 3;
    localparam int LAT    = DEB + 3;   // pin change to pulse, counted in clock edges

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                  RESET_N;
    logic [N_CH-1:0]       A, B, load;
    logic [WIDTH-1:0]      load_val;
    logic [N_CH*WIDTH-1:0] cnt_o [N_INST];
    logic [N_CH-1:0]       inc_o [N_INST];
    logic [N_CH-1:0]       dec_o [N_INST];
    logic [N_CH-1:0]       err_o [N_INST];

    quad_encoder_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .MAX_CNT(255), .DEB_LEN(DEB), .DETENT(1), .WRAP(0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .A(A), .B(B), .load(load), .load_val(load_val),
        .count(cnt_o[0]), .inc(inc_o[0]), .dec(dec_o[0]), .err(err_o[0]));
    quad_encoder_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .MAX_CNT(255), .DEB_LEN(DEB), .DETENT(1), .WRAP(1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .A(A), .B(B), .load(load), .load_val(load_val),
        .count(cnt_o[1]), .inc(inc_o[1]), .dec(dec_o[1]), .err(err_o[1]));
    quad_encoder_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .MAX_CNT(200), .DEB_LEN(DEB), .DETENT(0), .WRAP(1)) dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .A(A), .B(B), .load(load), .load_val(load_val),
        .count(cnt_o[2]), .inc(inc_o[2]), .dec(dec_o[2]), .err(err_o[2]));

    int p_detent [N_INST] = '{1, 1, 0};
    int p_wrap   [N_INST] = '{0, 1, 1};
    int p_max    [N_INST] = '{255, 255, 200};

    int               checks, errors;
    int               m_cnt  [N_INST][N_CH];
    int               m_disp [N_CH];
    logic [1:0]       m_ab   [N_CH];
    logic [N_CH-1:0]  e_inc  [N_INST];
    logic [N_CH-1:0]  e_dec  [N_INST];
    logic [N_CH-1:0]  e_err;

    // Position of an AB state along the clockwise Gray cycle 11,01,00,10
    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gseq(input int p);
        case (p % 4)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] pin(input int c);
        return {A[c], B[c]};
    endfunction

    // r: 0-3 clockwise, 4-7 counter-clockwise, 8 both pins flip, else hold
    function automatic logic [1:0] move(input logic [1:0] ab, input int r);
        if (r < 4)       return gseq(gpos(ab) + 1);
        else if (r < 8)  return gseq(gpos(ab) + 3);
        else if (r == 8) return ab ^ 2'b11;
        else             return ab;
    endfunction

    task automatic check(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s inst%0d got=%0h expected=%0h", tag, inst, got, exp);
        end
    endtask

    task automatic check_all(input bit pulse_now, input string tag);
        logic [N_CH*WIDTH-1:0] ev;
        logic [3*N_CH-1:0]     ep;
        for (int i = 0; i < N_INST; i++) begin
            for (int c = 0; c < N_CH; c++) ev[c*WIDTH +: WIDTH] = m_cnt[i][c][WIDTH-1:0];
            ep = pulse_now ? {e_inc[i], e_dec[i], e_err} : '0;
            check({tag, "_cnt"}, i, 32'(cnt_o[i]), 32'(ev));
            check({tag, "_pulse"}, i, 32'({inc_o[i], dec_o[i], err_o[i]}), 32'(ep));
        end
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < N_INST; i++) begin
            check({tag, "_cnt"}, i, 32'(cnt_o[i]), 32'd0);
            check({tag, "_pulse"}, i, 32'({inc_o[i], dec_o[i], err_o[i]}), 32'd0);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_disp[c] = 0;
            m_ab[c]   = 2'b11;
            for (int i = 0; i < N_INST; i++) m_cnt[i][c] = 0;
        end
    endtask

    // Drive new pin states, optionally load at cycle ld_cyc (0 = none), and check every cycle
    task automatic step(input logic [1:0] ab0, input logic [1:0] ab1, input logic [N_CH-1:0] ld,
                        input int ld_cyc, input logic [WIDTH-1:0] lv);
        logic [1:0]      nab [N_CH];
        logic [N_CH-1:0] s_cw, s_ccw, d_inc, d_dec;
        int d;
        nab[0] = ab0;
        nab[1] = ab1;
        for (int c = 0; c < N_CH; c++) begin
            d = (gpos(nab[c]) - gpos(m_ab[c]) + 4) % 4;
            s_cw[c]  = (d == 1);
            s_ccw[c] = (d == 3);
            e_err[c] = (d == 2);
            if (d == 2)      m_disp[c] = 0;
            else if (d == 1) m_disp[c] = m_disp[c] + 1;
            else if (d == 3) m_disp[c] = m_disp[c] - 1;
            d_inc[c] = s_cw[c]  && (nab[c] == 2'b11) && (m_disp[c] == 4);
            d_dec[c] = s_ccw[c] && (nab[c] == 2'b11) && (m_disp[c] == -4);
            if (nab[c] == 2'b11) m_disp[c] = 0;
            m_ab[c] = nab[c];
            A[c] = nab[c][1];
            B[c] = nab[c][0];
        end
        for (int i = 0; i < N_INST; i++) begin
            e_inc[i] = (p_detent[i] != 0) ? d_inc : s_cw;
            e_dec[i] = (p_detent[i] != 0) ? d_dec : s_ccw;
        end
        for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
            if (cyc == ld_cyc) begin
                load = ld;
                load_val = lv;
            end else begin
                load = '0;
            end
            @(posedge CLK);
            for (int i = 0; i < N_INST; i++) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (cyc == ld_cyc && ld[c]) begin
                        m_cnt[i][c] = (int'(lv) > p_max[i]) ? p_max[i] : int'(lv);
                    end else if (cyc == LAT && e_inc[i][c]) begin
                        m_cnt[i][c] = (m_cnt[i][c] == p_max[i]) ? ((p_wrap[i] != 0) ? 0 : p_max[i]) : m_cnt[i][c] + 1;
                    end else if (cyc == LAT && e_dec[i][c]) begin
                        m_cnt[i][c] = (m_cnt[i][c] == 0) ? ((p_wrap[i] != 0) ? p_max[i] : 0) : m_cnt[i][c] - 1;
                    end
                end
            end
            @(negedge CLK);
            check_all(cyc == LAT, "step");
        end
    endtask

    initial begin
        logic [N_CH-1:0] ld;
        int ldc;
        checks   = 0;
        errors   = 0;
        RESET_N  = 1'b0;
        A        = 2'b11;
        B        = 2'b11;
        load     = '0;
        load_val = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_idle("reset");
        RESET_N = 1'b1;

        // One full clockwise detent on ch0
        for (int k = 0; k < 4; k++) step(move(pin(0), 0), pin(1), 2'b00, 0, 8'd0);

        // Bounce on A[0] shorter than the debounce window
        for (int k = 0; k < 5; k++) begin
            A[0] = ~A[0];
            @(negedge CLK);
            check_all(1'b0, "bounce");
        end
        A[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check_all(1'b0, "bounce");
        end

        // Load 250 then ten detents: saturate, wrap, and wrap at a reduced maximum
        step(pin(0), pin(1), 2'b01, 5, 8'd250);
        for (int k = 0; k < 40; k++) step(move(pin(0), 0), pin(1), 2'b00, 0, 8'd0);

        // Illegal jump, then the remaining half cycle back to idle counts nothing
        step(2'b00, pin(1), 2'b00, 0, 8'd0);
        step(2'b10, pin(1), 2'b00, 0, 8'd0);
        step(2'b11, pin(1), 2'b00, 0, 8'd0);

        // Simultaneous activity: ch0 clockwise, ch1 counter-clockwise from 5
        step(pin(0), pin(1), 2'b10, 5, 8'd5);
        for (int k = 0; k < 3; k++) step((k < 2) ? move(pin(0), 0) : pin(0), move(pin(1), 4), 2'b00, 0, 8'd0);
        step(move(pin(0), 0), move(pin(1), 4), 2'b00, 0, 8'd0);
        step(move(pin(0), 0), pin(1), 2'b00, 0, 8'd0);

        // Load coinciding with the completing step, then a clamped load
        for (int k = 0; k < 3; k++) step(move(pin(0), 0), move(pin(1), 0), 2'b00, 0, 8'd0);
        step(move(pin(0), 0), move(pin(1), 0), 2'b11, LAT, 8'd100);
        step(pin(0), pin(1), 2'b11, 5, 8'd230);

        // Randomised walk with occasional loads
        for (int k = 0; k < 80; k++) begin
            ld  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ldc = ($urandom_range(0, 1) == 0) ? 5 : LAT;
            step(move(pin(0), int'($urandom_range(0, 9))), move(pin(1), int'($urandom_range(0, 9))),
                 ld, ldc, 8'($urandom_range(0, 255)));
        end

        // Reset in the middle of a detent discards the partial phase
        step(pin(0), pin(1), 2'b11, 5, 8'd77);
        step(move(pin(0), 0), move(pin(1), 4), 2'b00, 0, 8'd0);
        step(move(pin(0), 0), move(pin(1), 4), 2'b00, 0, 8'd0);
        #2;
        RESET_N = 1'b0;
        #1;
        check_idle("midrst");
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
        step(pin(0), pin(1), 2'b00, 0, 8'd0);
        for (int k = 0; k < 10; k++) step(move(pin(0), 0), move(pin(1), 4), 2'b00, 0, 8'd0);
        for (int k = 0; k < 12; k++) begin
            step(move(pin(0), int'($urandom_range(0, 9))), move(pin(1), int'($urandom_range(0, 9))),
                 2'b00, 0, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
